// File: rtl/pong_game_engine.sv
// pong_game_engine: once-per-frame ball, paddle and score update with serve/play/game-over control.
// All positions are held in 11-bit signed registers so edge arithmetic cannot wrap.
module pong_game_engine #(
    parameter int FIELD_X_BEGIN      = 10,
    parameter int FIELD_X_END        = 629,
    parameter int FIELD_Y_BEGIN      = 10,
    parameter int FIELD_Y_END        = 469,
    parameter int BALL_RADIUS        = 4,
    parameter int PADDLE_RADIUS      = 30,
    parameter int PADDLE_THICKNESS   = 8,
    parameter int LEFT_PADDLE_BEGIN  = 20,
    parameter int RIGHT_PADDLE_BEGIN = 612,
    parameter int BALL_SPEED         = 2,
    parameter int PADDLE_SPEED       = 4,
    parameter int SERVE_DELAY        = 60,
    parameter int WIN_SCORE          = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    output logic [9:0] ball_loc_x,
    output logic [9:0] ball_loc_y,
    output logic [9:0] left_paddle_loc,
    output logic [9:0] right_paddle_loc,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       game_over
);
    localparam logic signed [10:0] CX    = 11'((FIELD_X_BEGIN + FIELD_X_END) / 2);
    localparam logic signed [10:0] CY    = 11'((FIELD_Y_BEGIN + FIELD_Y_END) / 2);
    localparam logic signed [10:0] XB    = 11'(FIELD_X_BEGIN);
    localparam logic signed [10:0] XE    = 11'(FIELD_X_END);
    localparam logic signed [10:0] YB    = 11'(FIELD_Y_BEGIN);
    localparam logic signed [10:0] YE    = 11'(FIELD_Y_END);
    localparam logic signed [10:0] R     = 11'(BALL_RADIUS);
    localparam logic signed [10:0] BS    = 11'(BALL_SPEED);
    localparam logic signed [10:0] PS    = 11'(PADDLE_SPEED);
    localparam logic signed [10:0] REACH = 11'(PADDLE_RADIUS + BALL_RADIUS);
    localparam logic signed [10:0] PMIN  = 11'(FIELD_Y_BEGIN + PADDLE_RADIUS);
    localparam logic signed [10:0] PMAX  = 11'(FIELD_Y_END - PADDLE_RADIUS);
    localparam logic signed [10:0] LFACE = 11'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS);
    localparam logic signed [10:0] RFACE = 11'(RIGHT_PADDLE_BEGIN);
    localparam logic signed [10:0] LRET  = 11'(LEFT_PADDLE_BEGIN + PADDLE_THICKNESS + BALL_RADIUS + 1);
    localparam logic signed [10:0] RRET  = 11'(RIGHT_PADDLE_BEGIN - BALL_RADIUS - 1);
    localparam logic signed [10:0] YTOP  = 11'(FIELD_Y_BEGIN + BALL_RADIUS + 1);
    localparam logic signed [10:0] YBOT  = 11'(FIELD_Y_END - BALL_RADIUS - 1);
    localparam int CW = $clog2(SERVE_DELAY + 1);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;

    state_t state;
    logic signed [10:0] bx, by, lp, rp;
    logic signed [10:0] nx, ny, ny_f, ld, rd, ld_abs, rd_abs, lp_n, rp_n;
    logic dx, dy, dy_f, top, bot, hit_l, hit_r, goal_r, goal_l, right_scored, win;
    logic [CW-1:0] cnt;
    logic [3:0] ls_inc, rs_inc;

    function automatic logic signed [10:0] paddle_step(input logic signed [10:0] p, input logic up, input logic down);
        logic signed [10:0] q;
        q = (up && !down) ? p - PS : (down && !up) ? p + PS : p;
        return (q < PMIN) ? PMIN : (q > PMAX) ? PMAX : q;
    endfunction

    assign lp_n   = paddle_step(lp, left_up, left_down);
    assign rp_n   = paddle_step(rp, right_up, right_down);
    assign nx     = dx ? bx + BS : bx - BS;
    assign ny     = dy ? by + BS : by - BS;
    assign top    = ny - R <= YB;
    assign bot    = ny + R >= YE;
    assign ny_f   = top ? YTOP : bot ? YBOT : ny;
    assign dy_f   = top ? 1'b1 : bot ? 1'b0 : dy;
    // Paddle overlap uses the pre-update ball row and paddle rows.
    assign ld     = by - lp;
    assign rd     = by - rp;
    assign ld_abs = ld[10] ? -ld : ld;
    assign rd_abs = rd[10] ? -rd : rd;
    assign hit_l  = !dx && (bx - R > LFACE) && (nx - R <= LFACE) && (ld_abs <= REACH);
    assign hit_r  = dx && (bx + R < RFACE) && (nx + R >= RFACE) && (rd_abs <= REACH);
    assign goal_r = !hit_l && !hit_r && (nx - R <= XB);
    assign goal_l = !hit_l && !hit_r && (nx + R >= XE);
    assign ls_inc = (left_score == 4'hF) ? left_score : left_score + 4'd1;
    assign rs_inc = (right_score == 4'hF) ? right_score : right_score + 4'd1;
    assign win    = right_scored ? (rs_inc == 4'(WIN_SCORE)) : (ls_inc == 4'(WIN_SCORE));

    assign ball_loc_x       = bx[9:0];
    assign ball_loc_y       = by[9:0];
    assign left_paddle_loc  = lp[9:0];
    assign right_paddle_loc = rp[9:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bx           <= CX;
            by           <= CY;
            lp           <= CY;
            rp           <= CY;
            dx           <= 1'b1;
            dy           <= 1'b1;
            cnt          <= '0;
            left_score   <= 4'd0;
            right_score  <= 4'd0;
            right_scored <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= SERVE;
                    left_score  <= 4'd0;
                    right_score <= 4'd0;
                    bx          <= CX;
                    by          <= CY;
                    cnt         <= '0;
                end
                SERVE: if (frame_tick) begin
                    lp  <= lp_n;
                    rp  <= rp_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SERVE_DELAY - 1))
                        state <= PLAY;
                end
                PLAY: if (frame_tick) begin
                    lp <= lp_n;
                    rp <= rp_n;
                    if (goal_r || goal_l) begin
                        right_scored <= goal_r;
                        state        <= POINT;
                    end else begin
                        bx <= hit_l ? LRET : hit_r ? RRET : nx;
                        by <= ny_f;
                        dy <= dy_f;
                        dx <= hit_l ? 1'b1 : hit_r ? 1'b0 : dx;
                    end
                end
                POINT: begin
                    if (right_scored)
                        right_score <= rs_inc;
                    else
                        left_score <= ls_inc;
                    if (win) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= SERVE;
                        bx    <= CX;
                        by    <= CY;
                        cnt   <= '0;
                        dx    <= !right_scored;
                        dy    <= 1'b1;
                    end
                end
                GAME_OVER: if (start) begin
                    state     <= IDLE;
                    game_over <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: scoreboard bench; a behavioural game model queues the expected outputs of every cycle.
module tb_pong_game_engine;
    logic clk = 1'b0;
    logic reset, frame_tick, start, left_up, left_down, right_up, right_down;
    logic [9:0] ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc;
    logic [3:0] left_score, right_score;
    logic game_over;

    pong_game_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
        .ball_loc_x(ball_loc_x), .ball_loc_y(ball_loc_y),
        .left_paddle_loc(left_paddle_loc), .right_paddle_loc(right_paddle_loc),
        .left_score(left_score), .right_score(right_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int mst, mx, my, mdx, mdy, mlp, mrp, mls, mrs, mcnt;
    bit m_right_scored, lhit_seen;
    int ymin = 1023, ymax = 0;
    logic [48:0] sb[$];

    task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int pad(input int p, input bit u, input bit d);
        int q;
        q = (u && !d) ? p - 4 : (d && !u) ? p + 4 : p;
        return q < 40 ? 40 : q > 439 ? 439 : q;
    endfunction

    task automatic model_reset();
        mst = 0; mx = 319; my = 239; mdx = 1; mdy = 1;
        mlp = 239; mrp = 239; mls = 0; mrs = 0; mcnt = 0;
        m_right_scored = 0;
    endtask

    // States: 0 idle, 1 serve, 2 play, 3 point, 4 game over.
    task automatic model_step();
        int nx, ny, ndy, nlp, nrp;
        bit hl, hr;
        nlp = pad(mlp, left_up, left_down);
        nrp = pad(mrp, right_up, right_down);
        case (mst)
            0: if (start) begin
                mst = 1; mls = 0; mrs = 0; mx = 319; my = 239; mcnt = 0;
            end
            1: if (frame_tick) begin
                mlp = nlp; mrp = nrp; mcnt++;
                if (mcnt == 60) mst = 2;
            end
            2: if (frame_tick) begin
                nx = mx + 2 * mdx;
                ny = my + 2 * mdy;
                ndy = mdy;
                if (ny - 4 <= 10) begin ny = 15; ndy = 1; end
                else if (ny + 4 >= 469) begin ny = 464; ndy = -1; end
                hl = mdx < 0 && mx - 4 > 28 && nx - 4 <= 28 && iabs(my - mlp) <= 34;
                hr = mdx > 0 && mx + 4 < 612 && nx + 4 >= 612 && iabs(my - mrp) <= 34;
                if (hl) begin
                    mx = 33; mdx = 1; my = ny; mdy = ndy; lhit_seen = 1;
                end else if (hr) begin
                    mx = 607; mdx = -1; my = ny; mdy = ndy;
                end else if (nx - 4 <= 10) begin
                    m_right_scored = 1; mst = 3;
                end else if (nx + 4 >= 629) begin
                    m_right_scored = 0; mst = 3;
                end else begin
                    mx = nx; my = ny; mdy = ndy;
                end
                mlp = nlp; mrp = nrp;
            end
            3: begin
                if (m_right_scored) mrs = mrs < 15 ? mrs + 1 : 15;
                else mls = mls < 15 ? mls + 1 : 15;
                if ((m_right_scored ? mrs : mls) == 9) mst = 4;
                else begin
                    mst = 1; mx = 319; my = 239; mcnt = 0; mdy = 1;
                    mdx = m_right_scored ? -1 : 1;
                end
            end
            4: if (start) mst = 0;
            default: mst = 0;
        endcase
    endtask

    task automatic cyc();
        logic [48:0] exp;
        model_step();
        sb.push_back({10'(mx), 10'(my), 10'(mlp), 10'(mrp), 4'(mls), 4'(mrs), mst == 4});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        chk("cycle", {ball_loc_x, ball_loc_y, left_paddle_loc, right_paddle_loc, left_score, right_score, game_over}, exp);
        if (int'(ball_loc_y) < ymin) ymin = int'(ball_loc_y);
        if (int'(ball_loc_y) > ymax) ymax = int'(ball_loc_y);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1; cyc();
            frame_tick = 0; cyc(); cyc();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_x"}, ball_loc_x, 319);
        chk({tag, "_y"}, ball_loc_y, 239);
        chk({tag, "_lp"}, left_paddle_loc, 239);
        chk({tag, "_rp"}, right_paddle_loc, 239);
        chk({tag, "_ls"}, left_score, 0);
        chk({tag, "_rs"}, right_score, 0);
        chk({tag, "_go"}, game_over, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; frame_tick = 0; start = 0;
        left_up = 0; left_down = 0; right_up = 0; right_down = 0;
        lhit_seen = 0;
        #2 reset = 0;
        #1 chk_reset_values("rst");
        model_reset();
        @(posedge clk); #1 reset = 1;

        // start with a coincident tick that must not be counted
        start = 1; frame_tick = 1; cyc();
        start = 0; frame_tick = 0;
        left_up = 1;
        tick(1);  chk("lp_235", left_paddle_loc, 235);
        tick(48); chk("lp_43", left_paddle_loc, 43);
        tick(1);  chk("lp_clamp", left_paddle_loc, 40);
        tick(9);  chk("serve_x", ball_loc_x, 319);
        tick(1);  chk("play_x", ball_loc_x, 319); chk("play_y", ball_loc_y, 239);
        left_up = 0;
        tick(1);  chk("move_x", ball_loc_x, 321); chk("move_y", ball_loc_y, 241);
        left_down = 1;
        tick(2);  chk("lp_down", left_paddle_loc, 48);
        left_up = 1;
        tick(3);  chk("lp_both", left_paddle_loc, 48);
        left_up = 0; left_down = 0;

        #2 reset = 0;
        #1 chk_reset_values("rst_mid");
        sb.delete();
        model_reset();
        @(posedge clk); #1 reset = 1;

        // full game: right paddle tracks the ball; left tracks until its first hit, then plays randomly
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 9000 && mst != 4; i++) begin
            right_up = mrp > my; right_down = mrp < my;
            if (!lhit_seen) begin
                left_up = mlp > my; left_down = mlp < my;
            end else begin
                left_up = 1'($urandom_range(0, 1)); left_down = 1'($urandom_range(0, 1));
            end
            tick(1);
        end
        cyc();
        chk("game_over", game_over, 1);
        chk("final_rs", right_score, 9);
        chk("final_ls", left_score, 0);
        chk("ymin", ymin, 15);
        chk("ymax", ymax, 464);

        for (int i = 0; i < 10; i++) begin
            left_up = 1'(i); left_down = 0; right_up = 0; right_down = 1'(i);
            tick(1);
        end
        chk("frozen_go", game_over, 1);
        chk("frozen_rs", right_score, 9);
        left_up = 0; right_down = 0;

        start = 1; cyc(); start = 0;
        chk("idle_go", game_over, 0);
        chk("idle_rs", right_score, 9);
        cyc(); cyc();
        start = 1; cyc(); start = 0;
        chk("restart_rs", right_score, 0);
        chk("restart_x", ball_loc_x, 319);
        right_up = 1;
        tick(2);
        right_up = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Game-state stage directly upstream of the VGA pixel colour stage.
- Once per video frame it advances the ball, moves both paddles from button inputs, detects wall, paddle and goal events, keeps score, and runs the serve/play/game-over state machine.
- Outputs are registered and stay stable between frame ticks, so the colour stage samples consistent positions for a whole frame.

Parameters:
FIELD_X_BEGIN, 10, left field edge (pixels)
FIELD_X_END, 629, right field edge
FIELD_Y_BEGIN, 10, top field edge
FIELD_Y_END, 469, bottom field edge
BALL_RADIUS, 4, ball half-size
PADDLE_RADIUS, 30, paddle half-height
PADDLE_THICKNESS, 8, paddle width
LEFT_PADDLE_BEGIN, 20, left paddle leftmost column
RIGHT_PADDLE_BEGIN, 612, right paddle leftmost column
BALL_SPEED, 2, ball pixels per frame per axis
PADDLE_SPEED, 4, paddle pixels per frame
SERVE_DELAY, 60, frame ticks spent in SERVE
WIN_SCORE, 9, score that ends the game

Ports:
clk  in  1  system clock (25 MHz pixel clock)
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  single-cycle pulse once per frame (start of vertical blanking)
start  in  1  start / restart request, level-sampled
left_up, left_down  in  1 each  left player buttons (synchronised upstream)
right_up, right_down  in  1 each  right player buttons
ball_loc_x, ball_loc_y  out  10 each  ball centre
left_paddle_loc, right_paddle_loc  out  10 each  paddle centre row
left_score, right_score  out  4 each  scores
game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE.
  - Ball at centre: x = (FIELD_X_BEGIN+FIELD_X_END)/2 = 319, y = 239.
  - Paddles at 239; scores 0; game_over 0.
  - Ball direction dx=+1, dy=+1; serve counter 0.
  - Asserting reset mid-game forces all of these immediately.
- All arithmetic uses 11-bit signed internals; outputs are truncated to 10 bits. No unsigned underflow is allowed near edges.
- States:
  - IDLE: hold everything. On start=1 -> SERVE, with scores cleared, ball centred and counter cleared. A frame_tick in the same cycle is not counted.
  - SERVE: ball held at centre; paddles move. Each frame_tick increments the counter. The tick that makes it reach SERVE_DELAY moves the state to PLAY; the ball does not move on that tick.
  - PLAY: on each frame_tick, paddles and ball update in the same cycle. Ball collision uses the paddle positions from before the update.
  - POINT: single cycle, no tick needed.
    - Increment the scorer's score.
    - If the new score equals WIN_SCORE -> GAME_OVER.
    - Otherwise -> SERVE: ball centred, counter 0, dx pointing toward the player who conceded, dy=+1.
  - GAME_OVER: game_over=1; ball, paddles and scores frozen. start=1 -> IDLE.
- start is ignored in SERVE, PLAY and POINT.
- Paddle update (SERVE and PLAY, on frame_tick):
  - up alone: loc -= PADDLE_SPEED. down alone: loc += PADDLE_SPEED. Both or neither: hold.
  - Clamp to [FIELD_Y_BEGIN+PADDLE_RADIUS, FIELD_Y_END-PADDLE_RADIUS] = [40, 439].
- Ball update (PLAY, on frame_tick):
  - Candidate nx = x + dx*BALL_SPEED, ny = y + dy*BALL_SPEED.
  - Vertical:
    - If ny-R <= FIELD_Y_BEGIN: y = FIELD_Y_BEGIN+R+1, dy=+1.
    - Else if ny+R >= FIELD_Y_END: y = FIELD_Y_END-R-1, dy=-1.
    - Else y = ny.
  - Left paddle face = LEFT_PADDLE_BEGIN+PADDLE_THICKNESS (28).
    - Hit when dx=-1, x-R > 28, nx-R <= 28, and |y-left_paddle_loc| <= PADDLE_RADIUS+R.
    - On hit: x = 28+R+1 = 33, dx=+1.
  - Right paddle face = RIGHT_PADDLE_BEGIN (612), mirrored.
    - Hit when dx=+1, x+R < 612, nx+R >= 612, and |y-right_paddle_loc| <= PADDLE_RADIUS+R.
    - On hit: x = 612-R-1 = 607, dx=-1.
  - Goal, checked only if no paddle hit:
    - nx-R <= FIELD_X_BEGIN -> right scores, enter POINT.
    - nx+R >= FIELD_X_END -> left scores, enter POINT.
    - The ball is not moved on a goal tick.
  - Otherwise x = nx.
  - A vertical bounce and a paddle hit may occur on the same tick; both apply.
- Scores saturate at 15. They never exceed WIN_SCORE in normal play.
- Output latency: all outputs change in the cycle after the qualifying frame_tick/start edge.

Test Plan:
1. Release reset -> ball (319,239), paddles 239, scores 0, game_over 0. Pulse reset low during PLAY -> same values immediately, before any clk edge.
2. start=1, then 60 frame_ticks -> state PLAY after the 60th tick with ball still (319,239). Next tick -> ball (321,241).
3. Hold left_up for 60 ticks -> left_paddle_loc 235, 231, ... 43, then clamps at 40. left_up and left_down together -> no movement.
4. Top bounce: ball at y=15 with dy=-1 on a tick -> y=15 (FIELD_Y_BEGIN+R+1), dy=+1. Bottom mirror: y=464, dy=+1 -> y=464, dy=-1.
5. Miss and hit:
   - Left paddle at 40, ball travelling left at y=239 until nx-R <= 10 -> right_score=1, ball re-centred, dx=-1, SERVE counter restarts.
   - Repeat with left paddle at 239 -> ball reflects to x=33 with dx=+1, no score.
6. Drive right_score to 9 -> game_over=1, all outputs frozen across 10 ticks. start -> IDLE. start again -> scores 0, SERVE.
